// File: rtl/int_mem_arb_pkg.sv
// Shared types and constants for the two-master internal SRAM arbiter.
// Master indices double as the bit positions of every 2-bit grant/ready vector.
package int_mem_arb_pkg;

  localparam logic MST_I = 1'b0;
  localparam logic MST_D = 1'b1;

  localparam int IOB_DATA_W = 32;
  localparam int IOB_ADDR_W = 13;

  typedef struct packed {
    logic                    avalid;
    logic [IOB_ADDR_W-1:0]   addr;
    logic [IOB_DATA_W-1:0]   wdata;
    logic [IOB_DATA_W/8-1:0] wstrb;
  } iob_req_t;

  typedef struct packed {
    logic [IOB_DATA_W-1:0] rdata;
    logic                  rvalid;
    logic                  ready;
  } iob_rsp_t;

  function automatic logic [1:0] mst_onehot(input logic m);
    return m ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/int_mem_arb_grant.sv
// Round-robin grant with a bounded hold window: the last winner keeps the
// SRAM for up to HOLD back-to-back accepts while the other master waits.
module rr_hold_grant
  import int_mem_arb_pkg::*;
#(
  parameter int HOLD   = 4,
  parameter int HOLD_W = $clog2(HOLD+1)
) (
  input  logic       clk_i,
  input  logic       arst_n_i,
  input  logic       cke_i,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic              last_q, last_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              keep;
  logic              win;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      last_q <= MST_D;
      cnt_q  <= '0;
    end else if (cke_i) begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  // A zero count means the previous run was broken by an idle cycle (or
  // reset), so a tie goes to the other master; out of reset that is I.
  always_comb begin
    keep  = (cnt_q != '0) && (cnt_q < HOLD_W'(HOLD));
    gnt_o = valid_i;
    if (&valid_i) gnt_o = mst_onehot(keep ? last_q : ~last_q);
  end

  assign win = gnt_o[MST_D];

  always_comb begin
    last_d = last_q;
    cnt_d  = '0;
    if (accept_i) begin
      if (win == last_q) begin
        cnt_d = (cnt_q == HOLD_W'(HOLD)) ? cnt_q : cnt_q + HOLD_W'(1);
      end else begin
        cnt_d  = HOLD_W'(1);
        last_d = win;
      end
    end
  end

endmodule

// File: rtl/int_mem_arb.sv
// Shares one single-port SRAM between the instruction and data IOb buses:
// one access per cycle, read data steered back to the issuing master.
module int_mem_arb
  import int_mem_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int HOLD   = 4,
  parameter int HOLD_W = $clog2(HOLD+1)
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                i_avalid_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  input  logic [DATA_W-1:0]   i_wdata_i,
  input  logic [DATA_W/8-1:0] i_wstrb_i,
  output logic [DATA_W-1:0]   i_rdata_o,
  output logic                i_rvalid_o,
  output logic                i_ready_o,
  input  logic                d_avalid_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wstrb_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_rvalid_o,
  output logic                d_ready_o,
  output logic                m_en_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic [DATA_W-1:0]   m_rdata_i
);

  localparam int STRB_W = DATA_W/8;

  logic [1:0]             vld, gnt, rdy;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata;
  logic [1:0][STRB_W-1:0] wstrb;
  logic                   run, acc, win, rd_acc;
  logic                   rd_pend_q, rd_pend_d;
  logic                   rd_own_q, rd_own_d;

  assign vld   = {d_avalid_i, i_avalid_i};
  assign addr  = {d_addr_i, i_addr_i};
  assign wdata = {d_wdata_i, i_wdata_i};
  assign wstrb = {d_wstrb_i, i_wstrb_i};

  // Reset is folded in so ready/m_en drop the instant reset asserts.
  assign run = cke_i & arst_n_i;

  rr_hold_grant #(
    .HOLD   (HOLD),
    .HOLD_W (HOLD_W)
  ) u_grant (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .valid_i  (vld),
    .accept_i (acc),
    .gnt_o    (gnt)
  );

  assign rdy       = gnt & vld & {2{run}};
  assign acc       = |rdy;
  assign win       = rdy[MST_D];
  assign i_ready_o = rdy[MST_I];
  assign d_ready_o = rdy[MST_D];

  always_comb begin
    m_en_o    = acc;
    m_addr_o  = '0;
    m_wdata_o = '0;
    m_wstrb_o = '0;
    if (acc) begin
      m_addr_o  = addr[win];
      m_wdata_o = wdata[win];
      m_wstrb_o = wstrb[win];
    end
  end

  assign rd_acc = acc & (wstrb[win] == '0);

  always_comb begin
    rd_pend_d = rd_acc;
    rd_own_d  = rd_acc ? win : rd_own_q;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rd_pend_q <= 1'b0;
      rd_own_q  <= MST_I;
    end else if (cke_i) begin
      rd_pend_q <= rd_pend_d;
      rd_own_q  <= rd_own_d;
    end
  end

  // SRAM data is passed through unregistered; the non-owner sees zero.
  assign i_rvalid_o = rd_pend_q & (rd_own_q == MST_I);
  assign d_rvalid_o = rd_pend_q & (rd_own_q == MST_D);
  assign i_rdata_o  = i_rvalid_o ? m_rdata_i : '0;
  assign d_rdata_o  = d_rvalid_o ? m_rdata_i : '0;

endmodule

// File: tb/tb_int_mem_arb.sv
// Bench for int_mem_arb: directed scenarios plus randomized traffic checked
// against a grant-history reference model, on HOLD=4 and HOLD=1 instances.
module tb_int_mem_arb;
  import int_mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n, cke, sram_clr, sel1;
  iob_req_t ir, dr;
  int checks, errors;

  logic [31:0] a_i_rdata, a_d_rdata, a_m_wdata, a_m_rdata;
  logic [31:0] b_i_rdata, b_d_rdata, b_m_wdata, b_m_rdata;
  logic        a_i_rvalid, a_i_ready, a_d_rvalid, a_d_ready, a_m_en;
  logic        b_i_rvalid, b_i_ready, b_d_rvalid, b_d_ready, b_m_en;
  logic [12:0] a_m_addr, b_m_addr;
  logic [3:0]  a_m_wstrb, b_m_wstrb;
  logic [31:0] o_i_rdata, o_d_rdata, o_m_wdata;
  logic        o_i_rvalid, o_i_ready, o_d_rvalid, o_d_ready, o_m_en;
  logic [12:0] o_m_addr;
  logic [3:0]  o_m_wstrb;

  always #5 clk = ~clk;

  int_mem_arb #(.DATA_W(32), .ADDR_W(13), .HOLD(4)) u_dut (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(cke),
    .i_avalid_i(ir.avalid), .i_addr_i(ir.addr), .i_wdata_i(ir.wdata), .i_wstrb_i(ir.wstrb),
    .i_rdata_o(a_i_rdata), .i_rvalid_o(a_i_rvalid), .i_ready_o(a_i_ready),
    .d_avalid_i(dr.avalid), .d_addr_i(dr.addr), .d_wdata_i(dr.wdata), .d_wstrb_i(dr.wstrb),
    .d_rdata_o(a_d_rdata), .d_rvalid_o(a_d_rvalid), .d_ready_o(a_d_ready),
    .m_en_o(a_m_en), .m_addr_o(a_m_addr), .m_wdata_o(a_m_wdata), .m_wstrb_o(a_m_wstrb),
    .m_rdata_i(a_m_rdata));

  int_mem_arb #(.DATA_W(32), .ADDR_W(13), .HOLD(1)) u_dut_h1 (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(cke),
    .i_avalid_i(ir.avalid), .i_addr_i(ir.addr), .i_wdata_i(ir.wdata), .i_wstrb_i(ir.wstrb),
    .i_rdata_o(b_i_rdata), .i_rvalid_o(b_i_rvalid), .i_ready_o(b_i_ready),
    .d_avalid_i(dr.avalid), .d_addr_i(dr.addr), .d_wdata_i(dr.wdata), .d_wstrb_i(dr.wstrb),
    .d_rdata_o(b_d_rdata), .d_rvalid_o(b_d_rvalid), .d_ready_o(b_d_ready),
    .m_en_o(b_m_en), .m_addr_o(b_m_addr), .m_wdata_o(b_m_wdata), .m_wstrb_o(b_m_wstrb),
    .m_rdata_i(b_m_rdata));

  assign o_i_rdata  = sel1 ? b_i_rdata  : a_i_rdata;
  assign o_d_rdata  = sel1 ? b_d_rdata  : a_d_rdata;
  assign o_i_rvalid = sel1 ? b_i_rvalid : a_i_rvalid;
  assign o_d_rvalid = sel1 ? b_d_rvalid : a_d_rvalid;
  assign o_i_ready  = sel1 ? b_i_ready  : a_i_ready;
  assign o_d_ready  = sel1 ? b_d_ready  : a_d_ready;
  assign o_m_en     = sel1 ? b_m_en     : a_m_en;
  assign o_m_addr   = sel1 ? b_m_addr   : a_m_addr;
  assign o_m_wdata  = sel1 ? b_m_wdata  : a_m_wdata;
  assign o_m_wstrb  = sel1 ? b_m_wstrb  : a_m_wstrb;

  function automatic logic [31:0] pat(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, a + 8'hC3};
  endfunction

  // SRAM macros: one-cycle read latency, output holds when not enabled.
  logic [31:0] sa [0:255];
  logic [31:0] sb [0:255];
  always @(posedge clk) begin
    if (sram_clr) begin
      for (int k = 0; k < 256; k++) sa[k] <= pat(k[7:0]);
    end else if (a_m_en) begin
      if (a_m_wstrb == 4'h0) a_m_rdata <= sa[a_m_addr[7:0]];
      else for (int b = 0; b < 4; b++)
        if (a_m_wstrb[b]) sa[a_m_addr[7:0]][8*b +: 8] <= a_m_wdata[8*b +: 8];
    end
  end
  always @(posedge clk) begin
    if (sram_clr) begin
      for (int k = 0; k < 256; k++) sb[k] <= pat(k[7:0]);
    end else if (b_m_en) begin
      if (b_m_wstrb == 4'h0) b_m_rdata <= sb[b_m_addr[7:0]];
      else for (int b = 0; b < 4; b++)
        if (b_m_wstrb[b]) sb[b_m_addr[7:0]][8*b +: 8] <= b_m_wdata[8*b +: 8];
    end
  end

  // Reference model: grant history per enabled cycle (-1 = idle), the last
  // master ever granted, one outstanding read, and a shadow memory.
  int          hist[$];
  int          last_ever, pend_own, e_win;
  bit          pend;
  logic [31:0] pend_data;
  logic [31:0] refm [0:255];
  logic [1:0]  e_rdy, e_rv;
  logic [31:0] e_ird, e_drd;
  iob_req_t    e_req;

  task automatic model_reset();
    hist.delete();
    last_ever = 1;
    pend = 1'b0; pend_own = 0; pend_data = '0;
    e_rdy = 2'b00;
  endtask

  task automatic model_predict(input int hl, input bit run_c);
    int streak;
    e_rdy = 2'b00; e_win = -1; streak = 0;
    if (run_c) begin
      if (ir.avalid && dr.avalid) begin
        if (hist.size() > 0 && hist[$] != -1)
          for (int k = hist.size()-1; k >= 0 && hist[k] == hist[$] && streak < hl; k--) streak++;
        e_win = (streak > 0 && streak < hl) ? hist[$] : 1 - last_ever;
      end else if (ir.avalid) e_win = 0;
      else if (dr.avalid) e_win = 1;
      if (e_win >= 0) e_rdy[e_win] = 1'b1;
    end
    e_req = (e_win == 1) ? dr : ir;
    e_rv  = pend ? (pend_own == 1 ? 2'b10 : 2'b01) : 2'b00;
    e_ird = (pend && pend_own == 0) ? pend_data : 32'h0;
    e_drd = (pend && pend_own == 1) ? pend_data : 32'h0;
  endtask

  task automatic model_commit(input bit run_c);
    if (!run_c) return;
    hist.push_back(e_win);
    pend = 1'b0;
    if (e_win >= 0) begin
      last_ever = e_win;
      if (e_req.wstrb == 4'h0) begin
        pend = 1'b1; pend_own = e_win; pend_data = refm[e_req.addr[7:0]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (e_req.wstrb[b]) refm[e_req.addr[7:0]][8*b +: 8] = e_req.wdata[8*b +: 8];
      end
    end
  endtask

  task automatic gen_req(input iob_req_t cur, input bit acc, input int pct, input bit wr_ok,
                         output iob_req_t nxt);
    nxt = cur;
    if (cur.avalid && !acc) return;
    nxt.avalid = ($urandom_range(99, 0) < pct);
    nxt.addr   = 13'($urandom_range(255, 0));
    nxt.wdata  = $urandom();
    nxt.wstrb  = (wr_ok && $urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 1)) : 4'h0;
    if (!nxt.avalid) nxt = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cke = 1'b1; ir = '0; dr = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic mem_clear();
    for (int k = 0; k < 256; k++) refm[k] = pat(k[7:0]);
    sram_clr = 1'b1;
    @(posedge clk); #1;
    sram_clr = 1'b0;
  endtask

  task automatic test_reset();
    sel1 = 1'b0;
    rst_n = 1'b0;
    ir = '{avalid:1'b1, addr:13'h5, wdata:32'h0, wstrb:4'h0};
    dr = '{avalid:1'b1, addr:13'h6, wdata:32'h0, wstrb:4'h0};
    @(negedge clk);
    checks++;
    if ({o_i_rvalid, o_d_rvalid, o_i_ready, o_d_ready, o_m_en} !== 5'b0) begin
      errors++; $display("FAIL reset_hold_outputs got %b exp 00000",
                         {o_i_rvalid, o_d_rvalid, o_i_ready, o_d_ready, o_m_en});
    end
    do_reset();
    @(negedge clk);
    checks++;
    if ({o_i_rvalid, o_d_rvalid, o_i_ready, o_d_ready, o_m_en} !== 5'b0) begin
      errors++; $display("FAIL reset_idle_ctrl got %b exp 00000",
                         {o_i_rvalid, o_d_rvalid, o_i_ready, o_d_ready, o_m_en});
    end
    checks++;
    if ({o_m_addr, o_m_wdata, o_m_wstrb, o_i_rdata, o_d_rdata} !== '0) begin
      errors++; $display("FAIL reset_idle_data got addr %h wd %h st %h ird %h drd %h exp all 0",
                         o_m_addr, o_m_wdata, o_m_wstrb, o_i_rdata, o_d_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_solo_read();
    sel1 = 1'b0;
    do_reset();
    mem_clear();
    dr = '{avalid:1'b1, addr:13'h010, wdata:32'hDEADBEEF, wstrb:4'hF};
    @(negedge clk);
    checks++;
    if ({o_i_ready, o_d_ready, o_m_en, o_m_addr, o_m_wdata, o_m_wstrb} !==
        {3'b011, 13'h010, 32'hDEADBEEF, 4'hF}) begin
      errors++; $display("FAIL solo_dwrite got rdy %b%b en %b a %h wd %h st %h exp 01 1 010 deadbeef f",
                         o_i_ready, o_d_ready, o_m_en, o_m_addr, o_m_wdata, o_m_wstrb);
    end
    @(posedge clk); #1;
    dr = '0;
    ir = '{avalid:1'b1, addr:13'h010, wdata:32'h0, wstrb:4'h0};
    @(negedge clk);
    checks++;
    if ({o_i_ready, o_d_ready, o_m_en, o_m_addr, o_m_wstrb} !== {3'b101, 13'h010, 4'h0}) begin
      errors++; $display("FAIL solo_iread_req got rdy %b%b en %b a %h st %h exp 10 1 010 0",
                         o_i_ready, o_d_ready, o_m_en, o_m_addr, o_m_wstrb);
    end
    checks++;
    if ({o_i_rvalid, o_d_rvalid} !== 2'b00) begin
      errors++; $display("FAIL solo_write_no_rvalid got %b exp 00", {o_i_rvalid, o_d_rvalid});
    end
    @(posedge clk); #1;
    ir = '0;
    @(negedge clk);
    checks++;
    if ({o_i_rvalid, o_d_rvalid, o_m_en, o_i_rdata, o_d_rdata} !== {3'b100, 32'hDEADBEEF, 32'h0}) begin
      errors++; $display("FAIL solo_iread_ret got rv %b%b en %b ird %h drd %h exp 10 0 deadbeef 0",
                         o_i_rvalid, o_d_rvalid, o_m_en, o_i_rdata, o_d_rdata);
    end
  endtask

  task automatic test_write_vs_return();
    @(posedge clk); #1;
    ir = '{avalid:1'b1, addr:13'h010, wdata:32'h0, wstrb:4'h0};
    @(negedge clk);
    checks++;
    if (o_i_ready !== 1'b1) begin
      errors++; $display("FAIL wvr_iread_ready got %b exp 1", o_i_ready);
    end
    @(posedge clk); #1;
    ir = '0;
    dr = '{avalid:1'b1, addr:13'h020, wdata:32'h12345678, wstrb:4'hF};
    @(negedge clk);
    checks++;
    if ({o_d_ready, o_i_ready, o_m_en, o_m_addr, o_m_wdata, o_m_wstrb} !==
        {3'b101, 13'h020, 32'h12345678, 4'hF}) begin
      errors++; $display("FAIL wvr_dwrite got rdy d%b i%b en %b a %h wd %h st %h exp 1 0 1 020 12345678 f",
                         o_d_ready, o_i_ready, o_m_en, o_m_addr, o_m_wdata, o_m_wstrb);
    end
    checks++;
    if ({o_i_rvalid, o_d_rvalid, o_i_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      errors++; $display("FAIL wvr_iret got rv %b%b ird %h exp 10 deadbeef", o_i_rvalid, o_d_rvalid, o_i_rdata);
    end
    @(posedge clk); #1;
    dr = '0;
    ir = '{avalid:1'b1, addr:13'h020, wdata:32'h0, wstrb:4'h0};
    @(negedge clk);
    checks++;
    if ({o_i_rvalid, o_d_rvalid, o_i_ready} !== 3'b001) begin
      errors++; $display("FAIL wvr_no_drvalid got rv %b%b irdy %b exp 00 1", o_i_rvalid, o_d_rvalid, o_i_ready);
    end
    @(posedge clk); #1;
    ir = '0;
    @(negedge clk);
    checks++;
    if ({o_i_rvalid, o_d_rvalid, o_i_rdata} !== {2'b10, 32'h12345678}) begin
      errors++; $display("FAIL wvr_readback got rv %b%b ird %h exp 10 12345678", o_i_rvalid, o_d_rvalid, o_i_rdata);
    end
  endtask

  task automatic test_cke_stall();
    sel1 = 1'b0;
    do_reset();
    dr = '{avalid:1'b1, addr:13'h020, wdata:32'h0, wstrb:4'h0};
    @(negedge clk);
    checks++;
    if (o_d_ready !== 1'b1) begin
      errors++; $display("FAIL cke_dread_ready got %b exp 1", o_d_ready);
    end
    @(posedge clk); #1;
    cke = 1'b0;
    ir = '{avalid:1'b1, addr:13'h010, wdata:32'h0, wstrb:4'h0};
    dr = '{avalid:1'b1, addr:13'h030, wdata:32'h0, wstrb:4'h0};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({o_i_ready, o_d_ready, o_m_en, o_d_rvalid, o_i_rvalid, o_d_rdata} !== {5'b00010, 32'h12345678}) begin
        errors++; $display("FAIL cke_stall_%0d got rdy %b%b en %b rv d%b i%b drd %h exp 00 0 1 0 12345678",
                           c, o_i_ready, o_d_ready, o_m_en, o_d_rvalid, o_i_rvalid, o_d_rdata);
      end
      @(posedge clk); #1;
    end
    cke = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_i_ready, o_d_ready, o_m_addr, o_d_rvalid, o_d_rdata} !== {2'b01, 13'h030, 1'b1, 32'h12345678}) begin
      errors++; $display("FAIL cke_resume got rdy %b%b a %h drv %b drd %h exp 01 030 1 12345678",
                         o_i_ready, o_d_ready, o_m_addr, o_d_rvalid, o_d_rdata);
    end
    @(posedge clk); #1;
    dr = '0;
    @(negedge clk);
    checks++;
    if ({o_i_ready, o_d_rvalid, o_d_rdata} !== {2'b11, pat(8'h30)}) begin
      errors++; $display("FAIL cke_d2_ret got irdy %b drv %b drd %h exp 1 1 %h",
                         o_i_ready, o_d_rvalid, o_d_rdata, pat(8'h30));
    end
    @(posedge clk); #1;
    ir = '0;
    @(negedge clk);
    checks++;
    if ({o_i_rvalid, o_i_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL cke_i_ret got irv %b ird %h exp 1 deadbeef", o_i_rvalid, o_i_rdata);
    end
  endtask

  task automatic test_async_reset();
    sel1 = 1'b0;
    do_reset();
    dr = '{avalid:1'b1, addr:13'h020, wdata:32'h0, wstrb:4'h0};
    @(posedge clk); #1;
    ir = '{avalid:1'b1, addr:13'h010, wdata:32'h0, wstrb:4'h0};
    dr = '{avalid:1'b1, addr:13'h030, wdata:32'h0, wstrb:4'h0};
    #2;
    checks++;
    if ({o_d_rvalid, o_i_ready, o_d_ready} !== 3'b101) begin
      errors++; $display("FAIL arst_pre got drv %b rdy %b%b exp 1 01", o_d_rvalid, o_i_ready, o_d_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_i_rvalid, o_d_rvalid, o_i_ready, o_d_ready, o_m_en} !== 5'b0) begin
      errors++; $display("FAIL arst_immediate got %b exp 00000",
                         {o_i_rvalid, o_d_rvalid, o_i_ready, o_d_ready, o_m_en});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_i_ready, o_d_ready, o_i_rvalid, o_d_rvalid} !== 4'b1000) begin
      errors++; $display("FAIL arst_first_tie got rdy %b%b rv %b%b exp 10 00",
                         o_i_ready, o_d_ready, o_i_rvalid, o_d_rvalid);
    end
    @(posedge clk); #1;
    ir = '0;
    @(negedge clk);
    checks++;
    if ({o_d_ready, o_i_rvalid, o_i_rdata} !== {2'b11, 32'hDEADBEEF}) begin
      errors++; $display("FAIL arst_after got drdy %b irv %b ird %h exp 1 1 deadbeef",
                         o_d_ready, o_i_rvalid, o_i_rdata);
    end
    @(posedge clk); #1;
    dr = '0;
  endtask

  task automatic test_contention(input int hl, input bit s, input int n);
    int iw, dw;
    iob_req_t nx;
    sel1 = s;
    do_reset();
    mem_clear();
    model_reset();
    iw = 0; dw = 0;
    for (int c = 0; c < n; c++) begin
      gen_req(ir, e_rdy[0], 100, 1'b0, nx); ir = nx;
      gen_req(dr, e_rdy[1], 100, 1'b0, nx); dr = nx;
      model_predict(hl, 1'b1);
      @(negedge clk);
      checks++;
      if ({o_d_ready, o_i_ready} !== (((c / hl) % 2 == 1) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL cont_h%0d_seq cyc %0d got d%b i%b exp grant %s", hl, c,
                           o_d_ready, o_i_ready, ((c / hl) % 2 == 1) ? "D" : "I");
      end
      checks++;
      if ({o_d_ready, o_i_ready, o_m_en, o_m_addr} !== {e_rdy, 1'b1, e_req.addr}) begin
        errors++; $display("FAIL cont_h%0d_req cyc %0d got rdy %b en %b a %h exp %b 1 %h", hl, c,
                           {o_d_ready, o_i_ready}, o_m_en, o_m_addr, e_rdy, e_req.addr);
      end
      checks++;
      if ({o_d_rvalid, o_i_rvalid, o_d_rdata, o_i_rdata} !== {e_rv, e_drd, e_ird}) begin
        errors++; $display("FAIL cont_h%0d_rsp cyc %0d got rv %b drd %h ird %h exp %b %h %h", hl, c,
                           {o_d_rvalid, o_i_rvalid}, o_d_rdata, o_i_rdata, e_rv, e_drd, e_ird);
      end
      iw = o_i_ready ? 0 : iw + 1;
      dw = o_d_ready ? 0 : dw + 1;
      checks++;
      if (iw > hl || dw > hl) begin
        errors++; $display("FAIL cont_h%0d_wait cyc %0d got waits i%0d d%0d exp <= %0d", hl, c, iw, dw, hl);
      end
      model_commit(1'b1);
      @(posedge clk); #1;
    end
    ir = '0; dr = '0;
  endtask

  task automatic test_random_traffic(input int n);
    iob_req_t nx;
    sel1 = 1'b0;
    do_reset();
    mem_clear();
    model_reset();
    for (int c = 0; c < n; c++) begin
      gen_req(ir, e_rdy[0], 60, 1'b1, nx); ir = nx;
      gen_req(dr, e_rdy[1], 60, 1'b1, nx); dr = nx;
      cke = ($urandom_range(9, 0) != 0);
      model_predict(4, cke);
      @(negedge clk);
      checks++;
      if ({o_d_ready, o_i_ready, o_m_en} !== {e_rdy, e_win >= 0}) begin
        errors++; $display("FAIL rand_grant cyc %0d got rdy %b en %b exp %b %b", c,
                           {o_d_ready, o_i_ready}, o_m_en, e_rdy, e_win >= 0);
      end
      if (e_win >= 0) begin
        checks++;
        if ({o_m_addr, o_m_wdata, o_m_wstrb} !== {e_req.addr, e_req.wdata, e_req.wstrb}) begin
          errors++; $display("FAIL rand_sram cyc %0d got a %h wd %h st %h exp %h %h %h", c,
                             o_m_addr, o_m_wdata, o_m_wstrb, e_req.addr, e_req.wdata, e_req.wstrb);
        end
      end
      checks++;
      if ({o_d_rvalid, o_i_rvalid, o_d_rdata, o_i_rdata} !== {e_rv, e_drd, e_ird}) begin
        errors++; $display("FAIL rand_rsp cyc %0d got rv %b drd %h ird %h exp %b %h %h", c,
                           {o_d_rvalid, o_i_rvalid}, o_d_rdata, o_i_rdata, e_rv, e_drd, e_ird);
      end
      model_commit(cke);
      @(posedge clk); #1;
    end
    cke = 1'b1; ir = '0; dr = '0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; cke = 1'b1; sram_clr = 1'b0; sel1 = 1'b0;
    ir = '0; dr = '0;
    e_rdy = 2'b00;
    test_reset();
    test_solo_read();
    test_write_vs_return();
    test_cke_stall();
    test_async_reset();
    test_contention(4, 1'b0, 24);
    test_random_traffic(400);
    test_contention(1, 1'b1, 16);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
